// File: rtl/div_16_by_8_seq.sv
// Sequential unsigned restoring divider (DIVIDEND_W / DIVISOR_W) with a start/done handshake.
// Optional macro DIV_RADIX4_EN chains two restoring steps per CALC cycle.
module div_16_by_8_seq #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

`ifdef DIV_RADIX4_EN
    localparam int ITERS = DIVIDEND_W / 2;
`else
    localparam int ITERS = DIVIDEND_W;
`endif
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // acc shifts dividend bits out at the top while quotient bits enter at the bottom.
    typedef struct packed {
        logic [DIVISOR_W-1:0]  prem;
        logic [DIVIDEND_W-1:0] acc;
    } step_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    step_t                 work, work_n, step_mid, step_out;
    logic [DIVISOR_W-1:0]  dsr, dsr_n;
    logic [DIVIDEND_W-1:0] quotient_n;
    logic [DIVISOR_W-1:0]  remainder_n;
    logic                  busy_n, done_n, div_by_zero_n;

    function automatic step_t div_step(input step_t s, input logic [DIVISOR_W-1:0] d);
        step_t                r;
        logic [DIVISOR_W:0]   sh;
        logic [DIVISOR_W:0]   diff;
        logic                 ge;
        sh     = {s.prem, s.acc[DIVIDEND_W-1]};
        diff   = sh - {1'b0, d};
        ge     = (sh >= {1'b0, d});
        r.prem = ge ? diff[DIVISOR_W-1:0] : sh[DIVISOR_W-1:0];
        r.acc  = {s.acc[DIVIDEND_W-2:0], ge};
        return r;
    endfunction

    always_comb begin
        step_mid = div_step(work, dsr);
`ifdef DIV_RADIX4_EN
        step_out = div_step(step_mid, dsr);
`else
        step_out = step_mid;
`endif
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_n       = state;
        cnt_n         = cnt;
        work_n        = work;
        dsr_n         = dsr;
        quotient_n    = quotient;
        remainder_n   = remainder;
        busy_n        = busy;
        done_n        = 1'b0;
        div_by_zero_n = div_by_zero;

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    dsr_n         = divisor;
                    work_n.acc    = dividend;
                    work_n.prem   = '0;
                    cnt_n         = '0;
                    if (divisor == '0) begin
                        state_n       = DONE;
                        quotient_n    = '1;
                        remainder_n   = dividend[DIVISOR_W-1:0];
                        div_by_zero_n = 1'b1;
                        busy_n        = 1'b0;
                        done_n        = 1'b1;
                    end else begin
                        state_n       = CALC;
                        quotient_n    = '0;
                        remainder_n   = '0;
                        div_by_zero_n = 1'b0;
                        busy_n        = 1'b1;
                    end
                end
            end
            CALC: begin
                work_n = step_out;
                cnt_n  = cnt + 1'b1;
                if (cnt == CNT_W'(ITERS - 1)) begin
                    state_n     = DONE;
                    quotient_n  = step_out.acc;
                    remainder_n = step_out.prem;
                    busy_n      = 1'b0;
                    done_n      = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            work        <= '0;
            dsr         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            work        <= work_n;
            dsr         <= dsr_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            busy        <= busy_n;
            done        <= done_n;
            div_by_zero <= div_by_zero_n;
        end
    end

endmodule

// File: tb/tb_div_16_by_8_seq.sv
// Directed and randomized self-checking bench for div_16_by_8_seq.
// Build with DIV_RADIX4_EN defined to check the 8-cycle variant.
module tb_div_16_by_8_seq;

`ifdef DIV_RADIX4_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 16;
`endif
    localparam int MAX_WAIT = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    div_16_by_8_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start for one edge (E0); returns 1 ns after E0.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; flags any cycle with busy low before done.
    task automatic wait_done(output int n, output bit busy_gap);
        n        = 0;
        busy_gap = 1'b0;
        while (done !== 1'b1 && n < MAX_WAIT) begin
            if (busy !== 1'b1) busy_gap = 1'b1;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        tests_run++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 27'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        bit gap;
        run_op(16'd1000, 8'd7);
        dividend = 16'hABCD;
        divisor  = 8'd3;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_after_start: got busy=%b done=%b, want 1 0", busy, done);
        end
        wait_done(n, gap);
        tests_run++;
        if (n !== LAT || gap) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d cycles busy_gap=%b, want %0d cycles no gap", n, gap, LAT);
        end
        tests_run++;
        if (quotient !== 16'd142 || remainder !== 8'd6 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b busy=%b, want 142 6 0 0",
                     quotient, remainder, div_by_zero, busy);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || quotient !== 16'd142 || remainder !== 8'd6) begin
            tests_failed++;
            $display("FAIL basic_done_pulse_hold: got done=%b q=%0d r=%0d, want 0 142 6", done, quotient, remainder);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] a_vec [3] = '{16'hFFFF, 16'hFFFF, 16'd100};
        logic [7:0]  b_vec [3] = '{8'h01,    8'hFF,    8'd200};
        logic [15:0] q_vec [3] = '{16'hFFFF, 16'd257,  16'd0};
        logic [7:0]  r_vec [3] = '{8'd0,     8'd0,     8'd100};
        int n;
        bit gap;
        for (int i = 0; i < 3; i++) begin
            run_op(a_vec[i], b_vec[i]);
            wait_done(n, gap);
            tests_run++;
            if (n !== LAT || quotient !== q_vec[i] || remainder !== r_vec[i] || div_by_zero !== 1'b0) begin
                tests_failed++;
                $display("FAIL boundary_%0d: got cycles=%0d q=%h r=%h dbz=%b, want %0d %h %h 0",
                         i, n, quotient, remainder, div_by_zero, LAT, q_vec[i], r_vec[i]);
            end
            tick();
        end
    endtask

    task automatic test_div_by_zero();
        int n;
        bit gap;
        run_op(16'h1234, 8'd0);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || div_by_zero !== 1'b1 ||
            quotient !== 16'hFFFF || remainder !== 8'h34) begin
            tests_failed++;
            $display("FAIL dbz_result: got done=%b busy=%b dbz=%b q=%h r=%h, want 1 0 1 ffff 34",
                     done, busy, div_by_zero, quotient, remainder);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL dbz_hold: got done=%b dbz=%b q=%h, want 0 1 ffff", done, div_by_zero, quotient);
        end
        run_op(16'd100, 8'd7);
        tests_run++;
        if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL dbz_clear: got dbz=%b busy=%b, want 0 1", div_by_zero, busy);
        end
        wait_done(n, gap);
        tests_run++;
        if (n !== LAT || quotient !== 16'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL dbz_next_op: got cycles=%0d q=%0d r=%0d dbz=%b, want %0d 14 2 0",
                     n, quotient, remainder, div_by_zero, LAT);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int n;
        bit gap;
        run_op(16'd1000, 8'd7);
        dividend = 16'd50;
        divisor  = 8'd3;
        for (int i = 1; i <= 3; i++) begin
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        wait_done(n, gap);
        tests_run++;
        if (n + 3 !== LAT || gap || quotient !== 16'd142 || remainder !== 8'd6) begin
            tests_failed++;
            $display("FAIL busy_start_ignored: got cycles=%0d q=%0d r=%0d, want %0d 142 6",
                     n + 3, quotient, remainder, LAT);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        bit gap;
        run_op(16'd1000, 8'd7);
        wait_done(n, gap);
        dividend = 16'd50;
        divisor  = 8'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
        end
        wait_done(n, gap);
        tests_run++;
        if (n !== LAT || quotient !== 16'd16 || remainder !== 8'd2) begin
            tests_failed++;
            $display("FAIL b2b_result: got cycles=%0d q=%0d r=%0d, want %0d 16 2", n, quotient, remainder, LAT);
        end
        tick();
    endtask

    task automatic test_reset_mid_calc();
        bit saw_done;
        run_op(16'd1000, 8'd7);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 27'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("FAIL mid_reset_no_done: got done/busy activity after abort, want none");
        end
    endtask

    task automatic test_sweep();
        logic [15:0] a;
        logic [7:0]  b;
        int n;
        bit gap;
        int prints = 0;
        for (int i = 0; i < 1500; i++) begin
            a = 16'($urandom);
            b = 8'($urandom_range(1, 255));
            run_op(a, b);
            wait_done(n, gap);
            tests_run++;
            if (n !== LAT || quotient !== a / 16'(b) ||
                32'(quotient) * 32'(b) + 32'(remainder) !== 32'(a) || remainder >= b) begin
                tests_failed++;
                if (prints < 10) begin
                    prints++;
                    $display("FAIL sweep %0d/%0d: got cycles=%0d q=%0d r=%0d, want %0d q=%0d r=%0d",
                             a, b, n, quotient, remainder, LAT, a / 16'(b), a % 16'(b));
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_by_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_calc();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
